// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and data requesters, the
// arbiter and the single-port RAM; the master side drives requests and ram_rdata.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [1:0]    lat_cfg;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          if_done;
  logic          mem_done;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] mem_rdata;
  logic          if_stall;
  logic          mem_stall;
  logic          busy;

  modport master (
    output lat_cfg, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata, if_done, mem_done,
    input  if_rdata, mem_rdata, if_stall, mem_stall, busy
  );

  modport slave (
    input  lat_cfg, if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata, if_done, mem_done,
    output if_rdata, mem_rdata, if_stall, mem_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter for one single-port RAM with programmable
// wait states; alternates on conflict, one access in flight, done pulse in RESP.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IF_ACC  = 2'd1,
    S_MEM_ACC = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic [1:0]    lat_q;
  logic          last_mem_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          we_q;
  logic          if_done_q;
  logic          mem_done_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] mem_rdata_q;

  logic in_acc;
  logic final_cyc;
  logic grant_mem;

  always_comb begin
    in_acc    = (state_q == S_IF_ACC) || (state_q == S_MEM_ACC);
    final_cyc = in_acc && (cnt_q == lat_q);
    // Data side wins unless both are asking and it was served last.
    grant_mem = bus.mem_req && (!bus.if_req || !last_mem_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      last_mem_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.mem_req || bus.if_req) begin
            lat_q   <= bus.lat_cfg;
            cnt_q   <= '0;
            addr_q  <= grant_mem ? bus.mem_addr : bus.if_addr;
            wdata_q <= grant_mem ? bus.mem_wdata : '0;
            we_q    <= grant_mem && bus.mem_we;
            state_q <= grant_mem ? S_MEM_ACC : S_IF_ACC;
          end
        end
        S_IF_ACC, S_MEM_ACC: begin
          if (cnt_q == lat_q) begin
            // Read data is captured even for writes; the requester ignores it.
            if (state_q == S_MEM_ACC) begin
              mem_rdata_q <= bus.ram_rdata;
              mem_done_q  <= 1'b1;
            end else begin
              if_rdata_q <= bus.ram_rdata;
              if_done_q  <= 1'b1;
            end
            last_mem_q <= (state_q == S_MEM_ACC);
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_en    = in_acc;
  assign bus.ram_we    = final_cyc && (state_q == S_MEM_ACC) && we_q;
  assign bus.ram_addr  = in_acc ? addr_q : '0;
  assign bus.ram_wdata = in_acc ? wdata_q : '0;
  assign bus.if_done   = if_done_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.if_stall  = bus.if_req && !if_done_q;
  assign bus.mem_stall = bus.mem_req && !mem_done_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 32, address width.
REQ-002 Parameter DW, 32, data width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 lat_cfg  input  2  extra wait cycles per access (0..3); sampled at grant only.
REQ-006 if_req  input  1  instruction-fetch request (level).
REQ-007 if_addr  input  AW  fetch address; stable while if_req high.
REQ-008 mem_req, mem_we  input  1 each  data request and write enable (level).
REQ-009 mem_addr, mem_wdata  input  AW, DW  data address and write data; stable while mem_req high.
REQ-010 ram_rdata  input  DW  single-port RAM read data, valid in the final access cycle.
REQ-011 ram_en, ram_we  output  1 each  RAM enable and write strobe.
REQ-012 ram_addr, ram_wdata  output  AW, DW  RAM address and write data.
REQ-013 if_done, mem_done  output  1 each  one-cycle completion pulses, registered.
REQ-014 if_rdata, mem_rdata  output  DW  registered read data, valid while the matching done is high.
REQ-015 if_stall, mem_stall  output  1 each  combinational: req & ~done.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, IF_ACC, MEM_ACC, RESP.
REQ-018 IDLE, mem_req only: next state MEM_ACC. if_req only: next state IF_ACC. Neither: stay in IDLE.
REQ-019 IDLE, both requests: grant the requester not served last (last_grant register); last_grant resets to IF, so mem wins the first conflict.
REQ-020 At grant edge: latch lat_q=lat_cfg, address, wdata, we (we=0 for IF), owner; clear wait counter cnt (2 bits) to 0.
REQ-021 ACC states: ram_en=1; ram_addr/ram_wdata from latched values.
REQ-022 ACC states: cnt increments each cycle; final cycle is cnt==lat_q.
REQ-023 ram_we=1 only in the final MEM_ACC cycle of a write, giving exactly one write per access.
REQ-024 Final ACC cycle edge: owner rdata register <= ram_rdata, even for writes; owner done <= 1; last_grant <= owner; next state RESP.
REQ-025 RESP lasts exactly one cycle with the done pulse. Both requests are ignored in RESP, then next state IDLE.
REQ-026 Requesters update or drop req/addr during the done cycle; a req still high in the following IDLE cycle is a new access.
REQ-027 Latency from req sampled in IDLE to done high = lat_q+2 cycles; ACC occupancy = lat_q+1 cycles.
REQ-028 Changes to lat_cfg, or to a non-owner request, during ACC have no effect on the current access.
REQ-029 A new request arriving during ACC/RESP waits in IDLE arbitration; there is no queueing beyond the level req.
REQ-030 Outside ACC: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-031 A deasserted owner req during ACC is illegal; the access still completes and done still pulses.

Reset
REQ-032 While rst_n=0 at a clock edge: state=IDLE, cnt=0, lat_q=0, last_grant=IF, if_done=mem_done=0, if_rdata=mem_rdata=0.
REQ-033 Reset mid-access aborts with no done pulse, and ram_en/ram_we are 0 in the next cycle.
REQ-034 After reset, the block is ready for arbitration in the first cycle rst_n=1.

Verification
REQ-035 lat_cfg=0, if_req at cycle 0, addr 0x100, ram_rdata=0xA5A5A5A5 -> ram_en in cycle 1 only, if_done + if_rdata=0xA5A5A5A5 in cycle 2.
REQ-036 lat_cfg=3, mem write, addr 0x40, data 0x1234 -> ram_en cycles 1-4, ram_we only cycle 4, mem_done cycle 5.
REQ-037 if_req and mem_req both high from reset, lat_cfg=1 -> grant order MEM, IF, MEM, IF (alternating); each done 3 cycles after its grant-sampling IDLE cycle.
REQ-038 lat_cfg changed 1->3 mid-access -> current access ends after 2 ACC cycles; the next access uses 3 wait cycles.
REQ-039 rst_n low in the second ACC cycle of a lat 2 read -> no done pulse, busy=0 next cycle, then a fresh if_req is served normally.
REQ-040 req held high through the done cycle -> a second access starts from IDLE, giving back-to-back dones lat_q+3 cycles apart.
